encoder_32_5_arb: RTL and testbench
===================================

ENCODER_32_5_ARB -- requirements
Module: encoder_32_5_arb

Interface
REQ-001 Parameter ROUND_ROBIN, default 0; 0 = fixed priority (lowest index wins), 1 = rotating priority.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 req  input  32  request lines; any bit high at a rising edge sets the matching pending bit.
REQ-005 mask  input  32  enable per line; 1 = line eligible for selection; a masked bit still stays pending.
REQ-006 out_valid  output  1  registered; out_index holds a granted line.
REQ-007 out_index  output  5  registered binary index of the granted line.
REQ-008 out_ready  input  1  consumer accepts out_index when high together with out_valid.
REQ-009 pending  output  32  registered pending-request vector.
REQ-010 pend_count  output  6  registered population count of pending, range 0..32.

Function
REQ-011 State machine SHALL have two states: IDLE and HOLD.
REQ-012 Each edge: pending_next = (pending & ~clr) | req; clr = one-hot of out_index when out_valid & out_ready, else 0.
REQ-013 Simultaneous req and clear on the same bit: set wins; the bit stays pending.
REQ-014 In IDLE, if (pending & mask) != 0 at an edge: load the selected index into out_index, set out_valid, go to HOLD.
REQ-015 In IDLE with (pending & mask) == 0: stay IDLE, out_valid = 0, out_index keeps its last value.
REQ-016 Selection uses the registered pending, not the current req: a req sampled at edge k first makes out_valid high after edge k+1 (2-cycle latency).
REQ-017 ROUND_ROBIN=0: selected index = lowest set bit of (pending & mask).
REQ-018 ROUND_ROBIN=1: search starts at (last_grant + 1) mod 32, ascending with wrap 31 -> 0; first eligible bit wins.
REQ-019 last_grant (5 bits, internal) updates to out_index on every accepted transfer; it is unused when ROUND_ROBIN=0.
REQ-020 In HOLD, out_valid and out_index SHALL stay stable until out_valid & out_ready at an edge, whatever req or mask do.
REQ-021 On acceptance: clear that pending bit (subject to REQ-013), drop out_valid, return to IDLE.
REQ-022 Back-to-back grants: at most one grant per 2 cycles; the next valid appears one edge after acceptance.
REQ-023 Masking the granted bit during HOLD SHALL NOT withdraw out_valid.
REQ-024 pend_count SHALL equal popcount(pending) in the same cycle.
REQ-025 All 32 bits pending and all enabled: each index is granted exactly once before any repeat in ROUND_ROBIN=1.

Reset
REQ-026 resetn low SHALL immediately force: pending = 0, pend_count = 0, out_valid = 0, out_index = 0, state = IDLE, last_grant = 31.
REQ-027 Reset asserted in HOLD discards the grant; no clear pulse and no last_grant update occur.
REQ-028 After resetn rises, the first edge behaves as IDLE with empty pending; req on that edge is captured.

Verification
REQ-029 Single request: mask=all 1s, req=0x0000_0100 pulsed for one edge, out_ready=1 -> out_valid high after the next edge with out_index=8; pending=0 one edge later; pend_count 1 -> 0.
REQ-030 Fixed priority: pending 0x8000_0011, ROUND_ROBIN=0, out_ready=1 -> grant order 0, 4, 31, with one idle cycle between grants.
REQ-031 Round robin: ROUND_ROBIN=1, req held at 0x0000_0005 -> grant order 0, 2, 0, 2, ... with no starvation.
REQ-032 Backpressure: out_ready=0 for 10 cycles while a new req=0x1 arrives, holding out_index=5 -> out_index stays 5 and out_valid stays high; pend_count=2; out_ready=1 -> grant 0 next.
REQ-033 Mask and set-wins: mask bit 3 = 0 with pending bit 3 -> no grant, pending keeps bit 3; req bit 3 on the accept edge of index 3 -> bit 3 stays pending and is granted again.
REQ-034 Async reset: drop resetn mid-HOLD between edges -> out_valid=0, pending=0, pend_count=0 immediately, with no clock edge.

Source files
------------

// File: rtl/encoder_32_5_arb.sv
// encoder_32_5_arb: 32-line request collector with a 5-bit grant encoder.
// Requests are latched into a pending vector. An eligible pending line
// (pending & mask) is selected and presented as out_index with out_valid.
// The grant is held until out_ready accepts it. Arbitration is either fixed
// priority (lowest index first) or rotating priority, chosen by ROUND_ROBIN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant presented; select from registered pending each edge
// HOLD  | out_valid/out_index frozen until accepted by out_ready

module encoder_32_5_arb #(
    parameter int unsigned ROUND_ROBIN = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] req,
    input  logic [31:0] mask,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [4:0]  out_index,
    output logic [31:0] pending,
    output logic [5:0]  pend_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [4:0]  last_grant;

    logic        accept;
    logic [31:0] clr;
    logic [31:0] pending_nxt;
    logic [31:0] eligible;
    logic [4:0]  search_base;
    logic [4:0]  cand;
    logic [4:0]  sel_index;
    logic        sel_found;
    logic [5:0]  pop_nxt;

    // A transfer completes when the held grant meets out_ready.
    assign accept = out_valid & out_ready;

    // Clear mask for the accepted line; a request on the same edge re-sets it.
    always_comb begin
        clr = '0;
        if (accept) begin
            clr[out_index] = 1'b1;
        end
        pending_nxt = (pending & ~clr) | req;
    end

    // Only registered pending lines that are enabled compete for the grant.
    assign eligible = pending & mask;

    // Rotating priority starts one past the previous grant; fixed starts at 0.
    assign search_base = (ROUND_ROBIN != 0) ? (last_grant + 5'd1) : 5'd0;

    // Walk the 32 lines from search_base upward with wrap; first eligible wins.
    always_comb begin
        sel_found = 1'b0;
        sel_index = '0;
        cand      = '0;
        for (int i = 0; i < 32; i++) begin
            cand = search_base + 5'(i);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_index = cand;
            end
        end
    end

    // Population count of the next pending vector so pend_count tracks pending.
    always_comb begin
        pop_nxt = '0;
        for (int i = 0; i < 32; i++) begin
            pop_nxt = pop_nxt + 6'(pending_nxt[i]);
        end
    end

    // Pending vector and its population count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending    <= '0;
            pend_count <= '0;
        end else begin
            pending    <= pending_nxt;
            pend_count <= pop_nxt;
        end
    end

    // Grant FSM: load a selection in IDLE, hold it stable in HOLD until accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_index  <= '0;
            last_grant <= 5'd31;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        out_index <= sel_index;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    // req and mask are ignored here; the grant stays frozen.
                    if (accept) begin
                        out_valid  <= 1'b0;
                        last_grant <= out_index;
                        state      <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_32_5_arb.sv
// Testbench for encoder_32_5_arb: one fixed-priority and one rotating-priority
// instance share stimulus; expected grant indices are queued per instance.

module tb_encoder_32_5_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] req;
    logic [31:0] mask;
    logic        out_ready;

    logic        out_valid0, out_valid1;
    logic [4:0]  out_index0, out_index1;
    logic [31:0] pending0, pending1;
    logic [5:0]  pend_count0, pend_count1;

    int checks = 0;
    int errors = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    encoder_32_5_arb #(.ROUND_ROBIN(0)) dut0 (
        .clk(clk), .resetn(resetn), .req(req), .mask(mask), .out_ready(out_ready),
        .out_valid(out_valid0), .out_index(out_index0),
        .pending(pending0), .pend_count(pend_count0)
    );

    encoder_32_5_arb #(.ROUND_ROBIN(1)) dut1 (
        .clk(clk), .resetn(resetn), .req(req), .mask(mask), .out_ready(out_ready),
        .out_valid(out_valid1), .out_index(out_index1),
        .pending(pending1), .pend_count(pend_count1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req       = '0;
        mask      = '1;
        out_ready = 1'b0;
        resetn    = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        req = '0; mask = '1; out_ready = 1'b0; resetn = 1'b0;
        #2;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %0b expected 0", out_valid0); end
        checks++; if (out_index0 !== 5'd0) begin errors++; $display("FAIL reset_index0 got %0d expected 0", out_index0); end
        checks++; if (pending0 !== 32'h0) begin errors++; $display("FAIL reset_pending0 got %h expected 0", pending0); end
        checks++; if (pend_count0 !== 6'd0) begin errors++; $display("FAIL reset_count0 got %0d expected 0", pend_count0); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %0b expected 0", out_valid1); end
        checks++; if (pending1 !== 32'h0) begin errors++; $display("FAIL reset_pending1 got %h expected 0", pending1); end
        req = 32'hFFFF_FFFF;
        tick();
        checks++; if (pending0 !== 32'h0) begin errors++; $display("FAIL reset_hold_pending0 got %h expected 0", pending0); end
        apply_reset();
    endtask

    task automatic test_single();
        int exp_idx;
        apply_reset();
        out_ready = 1'b1;
        req = 32'h0000_0100;
        q0.push_back(8);
        tick();
        req = '0;
        checks++; if (pending0 !== 32'h0000_0100) begin errors++; $display("FAIL single_pending got %h expected 00000100", pending0); end
        checks++; if (pend_count0 !== 6'd1) begin errors++; $display("FAIL single_count got %0d expected 1", pend_count0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL single_latency got valid %0b expected 0", out_valid0); end
        tick();
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL single_valid got %0b expected 1", out_valid0); end
        if (out_valid0 && out_ready && q0.size() > 0) begin
            exp_idx = q0.pop_front();
            checks++; if (out_index0 !== 5'(exp_idx)) begin errors++; $display("FAIL single_index got %0d expected %0d", out_index0, exp_idx); end
        end
        tick();
        checks++; if (pending0 !== 32'h0) begin errors++; $display("FAIL single_cleared got %h expected 0", pending0); end
        checks++; if (pend_count0 !== 6'd0) begin errors++; $display("FAIL single_count_after got %0d expected 0", pend_count0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL single_drop got %0b expected 0", out_valid0); end
    endtask

    task automatic test_fixed_priority();
        int exp_idx;
        int last_c;
        apply_reset();
        out_ready = 1'b1;
        req = 32'h8000_0011;
        q0.push_back(0); q0.push_back(4); q0.push_back(31);
        tick();
        req = '0;
        last_c = -1;
        for (int c = 0; c < 40 && q0.size() > 0; c++) begin
            if (out_valid0 && out_ready) begin
                exp_idx = q0.pop_front();
                checks++; if (out_index0 !== 5'(exp_idx)) begin errors++; $display("FAIL fixed_order got %0d expected %0d", out_index0, exp_idx); end
                if (last_c >= 0) begin
                    checks++; if (c - last_c != 2) begin errors++; $display("FAIL fixed_gap got %0d cycles expected 2", c - last_c); end
                end
                last_c = c;
            end
            tick();
        end
        checks++; if (q0.size() != 0) begin errors++; $display("FAIL fixed_timeout got %0d grants left expected 0", q0.size()); end
    endtask

    task automatic test_round_robin();
        int exp_idx;
        apply_reset();
        out_ready = 1'b1;
        req = 32'h0000_0005;
        for (int k = 0; k < 6; k++) begin
            q0.push_back(0);
            q1.push_back((k % 2 == 0) ? 0 : 2);
        end
        for (int c = 0; c < 40 && (q0.size() > 0 || q1.size() > 0); c++) begin
            tick();
            if (out_valid0 && out_ready && q0.size() > 0) begin
                exp_idx = q0.pop_front();
                checks++; if (out_index0 !== 5'(exp_idx)) begin errors++; $display("FAIL rr_fixed_inst got %0d expected %0d", out_index0, exp_idx); end
            end
            if (out_valid1 && out_ready && q1.size() > 0) begin
                exp_idx = q1.pop_front();
                checks++; if (out_index1 !== 5'(exp_idx)) begin errors++; $display("FAIL rr_order got %0d expected %0d", out_index1, exp_idx); end
            end
        end
        checks++; if (q1.size() != 0 || q0.size() != 0) begin errors++; $display("FAIL rr_timeout got %0d/%0d left expected 0", q0.size(), q1.size()); end
        req = '0;
    endtask

    task automatic test_all_lines();
        int exp_idx;
        apply_reset();
        out_ready = 1'b1;
        req = 32'hFFFF_FFFF;
        for (int k = 0; k < 32; k++) begin
            q0.push_back(k);
            q1.push_back(k);
        end
        tick();
        req = '0;
        checks++; if (pend_count0 !== 6'd32) begin errors++; $display("FAIL all_count got %0d expected 32", pend_count0); end
        checks++; if (pending1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL all_pending got %h expected ffffffff", pending1); end
        for (int c = 0; c < 100 && (q0.size() > 0 || q1.size() > 0); c++) begin
            tick();
            if (out_valid0 && out_ready && q0.size() > 0) begin
                exp_idx = q0.pop_front();
                checks++; if (out_index0 !== 5'(exp_idx)) begin errors++; $display("FAIL all_fixed got %0d expected %0d", out_index0, exp_idx); end
            end
            if (out_valid1 && out_ready && q1.size() > 0) begin
                exp_idx = q1.pop_front();
                checks++; if (out_index1 !== 5'(exp_idx)) begin errors++; $display("FAIL all_rr got %0d expected %0d", out_index1, exp_idx); end
            end
        end
        checks++; if (q1.size() != 0 || q0.size() != 0) begin errors++; $display("FAIL all_timeout got %0d/%0d left expected 0", q0.size(), q1.size()); end
        tick();
        checks++; if (pending1 !== 32'h0) begin errors++; $display("FAIL all_drained got %h expected 0", pending1); end
        checks++; if (pend_count0 !== 6'd0) begin errors++; $display("FAIL all_count_end got %0d expected 0", pend_count0); end
    endtask

    task automatic test_backpressure();
        int exp_idx;
        apply_reset();
        out_ready = 1'b0;
        req = 32'h0000_0020;
        tick();
        req = '0;
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_index0 !== 5'd5) begin errors++; $display("FAIL bp_first got %0b/%0d expected 1/5", out_valid0, out_index0); end
        req = 32'h0000_0001;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) req = '0;
            if (c == 3) mask = 32'hFFFF_FFDF;
            if (c == 7) mask = '1;
            checks++; if (out_valid0 !== 1'b1 || out_index0 !== 5'd5) begin errors++; $display("FAIL bp_hold cycle %0d got %0b/%0d expected 1/5", c, out_valid0, out_index0); end
        end
        checks++; if (pend_count0 !== 6'd2) begin errors++; $display("FAIL bp_count got %0d expected 2", pend_count0); end
        checks++; if (pending0 !== 32'h0000_0021) begin errors++; $display("FAIL bp_pending got %h expected 00000021", pending0); end
        out_ready = 1'b1;
        q0.push_back(5); q0.push_back(0);
        for (int c = 0; c < 10 && q0.size() > 0; c++) begin
            if (out_valid0 && out_ready) begin
                exp_idx = q0.pop_front();
                checks++; if (out_index0 !== 5'(exp_idx)) begin errors++; $display("FAIL bp_order got %0d expected %0d", out_index0, exp_idx); end
            end
            tick();
        end
        checks++; if (q0.size() != 0) begin errors++; $display("FAIL bp_timeout got %0d left expected 0", q0.size()); end
    endtask

    task automatic test_mask_set_wins();
        int exp_idx;
        apply_reset();
        out_ready = 1'b1;
        mask = 32'hFFFF_FFF7;
        req = 32'h0000_0008;
        tick();
        req = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (out_valid0 !== 1'b0 || pending0 !== 32'h8) begin errors++; $display("FAIL mask_block got %0b/%h expected 0/00000008", out_valid0, pending0); end
        end
        mask = '1;
        q0.push_back(3);
        tick();
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL mask_enable got %0b expected 1", out_valid0); end
        if (out_valid0 && q0.size() > 0) begin
            exp_idx = q0.pop_front();
            checks++; if (out_index0 !== 5'(exp_idx)) begin errors++; $display("FAIL mask_index got %0d expected %0d", out_index0, exp_idx); end
        end
        req = 32'h0000_0008;
        tick();
        req = '0;
        checks++; if (pending0 !== 32'h8 || pend_count0 !== 6'd1) begin errors++; $display("FAIL setwins got %h/%0d expected 00000008/1", pending0, pend_count0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL setwins_drop got %0b expected 0", out_valid0); end
        q0.push_back(3);
        tick();
        if (out_valid0 && q0.size() > 0) begin
            exp_idx = q0.pop_front();
            checks++; if (out_index0 !== 5'(exp_idx)) begin errors++; $display("FAIL setwins_regrant got %0d expected %0d", out_index0, exp_idx); end
        end
        checks++; if (q0.size() != 0) begin errors++; $display("FAIL setwins_timeout got %0d left expected 0", q0.size()); end
        tick();
        tick();
        checks++; if (out_valid0 !== 1'b0 || out_index0 !== 5'd3 || pending0 !== 32'h0) begin errors++; $display("FAIL idle_keep got %0b/%0d/%h expected 0/3/00000000", out_valid0, out_index0, pending0); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b0;
        req = 32'h0000_00F0;
        tick();
        req = '0;
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_index0 !== 5'd4) begin errors++; $display("FAIL areset_hold got %0b/%0d expected 1/4", out_valid0, out_index0); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b/%0b expected 0/0", out_valid0, out_valid1); end
        checks++; if (pending0 !== 32'h0 || pending1 !== 32'h0) begin errors++; $display("FAIL areset_pending got %h/%h expected 0/0", pending0, pending1); end
        checks++; if (pend_count0 !== 6'd0 || pend_count1 !== 6'd0) begin errors++; $display("FAIL areset_count got %0d/%0d expected 0/0", pend_count0, pend_count1); end
        checks++; if (out_index1 !== 5'd0) begin errors++; $display("FAIL areset_index got %0d expected 0", out_index1); end
        #3;
        resetn = 1'b1;
        out_ready = 1'b1;
        req = 32'h0000_0030;
        tick();
        req = '0;
        checks++; if (pending1 !== 32'h0000_0030) begin errors++; $display("FAIL post_reset_capture got %h expected 00000030", pending1); end
        tick();
        checks++; if (out_valid1 !== 1'b1 || out_index1 !== 5'd4) begin errors++; $display("FAIL post_reset_grant got %0b/%0d expected 1/4", out_valid1, out_index1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_fixed_priority();
        test_round_robin();
        test_all_lines();
        test_backpressure();
        test_mask_set_wins();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
